// File: rtl/multiplication_block_pkg.sv
// Shared encodings for the RV32M multiply block: operation selector and FSM states.
package multiplication_block_pkg;

  localparam int XLEN_DEFAULT = 32;

  // Same 2-bit selector space as the divider's DIV/DIVU/REM/REMU.
  typedef enum logic [1:0] {
    OP_MUL    = 2'b00,
    OP_MULH   = 2'b01,
    OP_MULHSU = 2'b10,
    OP_MULHU  = 2'b11
  } mul_op_e;

  typedef enum logic {
    STATE_IDLE = 1'b0,
    STATE_CALC = 1'b1
  } mul_state_e;

endpackage

// File: rtl/multiplication_unit.sv
// Unsigned radix-2 shift-add core: XLEN steps on operand magnitudes, then one done cycle.
module multiplication_unit
  import multiplication_block_pkg::*;
#(
  parameter int XLEN        = XLEN_DEFAULT,
  parameter int COUNT_WIDTH = $clog2(XLEN)
) (
  input  logic              clk,
  input  logic              srst,
  input  logic              start,
  input  logic [XLEN-1:0]   mcand_mag,
  input  logic [XLEN-1:0]   mplier_mag,
  output logic              busy,
  output logic              done,
  output logic [2*XLEN-1:0] product
);

  localparam logic [COUNT_WIDTH-1:0] LAST_COUNT = COUNT_WIDTH'(XLEN - 1);

  mul_state_e              state_reg, state_next;
  logic [COUNT_WIDTH-1:0]  count_reg;
  logic [2*XLEN-1:0]       acc_reg;
  logic [2*XLEN-1:0]       mcand_reg;
  logic [XLEN-1:0]         mplier_reg;
  logic                    steps_done_reg;

  always_comb begin
    state_next = state_reg;
    done       = 1'b0;
    case (state_reg)
      STATE_IDLE: if (start) state_next = STATE_CALC;
      STATE_CALC: begin
        // The edge after the last step hands the product out and leaves CALC.
        if (steps_done_reg) begin
          done       = 1'b1;
          state_next = STATE_IDLE;
        end
      end
      default: state_next = STATE_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      state_reg      <= STATE_IDLE;
      count_reg      <= '0;
      acc_reg        <= '0;
      mcand_reg      <= '0;
      mplier_reg     <= '0;
      steps_done_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (state_reg == STATE_IDLE && start) begin
        count_reg      <= '0;
        acc_reg        <= '0;
        mcand_reg      <= {{XLEN{1'b0}}, mcand_mag};
        mplier_reg     <= mplier_mag;
        steps_done_reg <= 1'b0;
      end else if (state_reg == STATE_CALC && !steps_done_reg) begin
        if (mplier_reg[0]) acc_reg <= acc_reg + mcand_reg;
        mcand_reg  <= mcand_reg << 1;
        mplier_reg <= mplier_reg >> 1;
        // Terminal count parks the counter instead of wrapping into another pass.
        if (count_reg == LAST_COUNT) steps_done_reg <= 1'b1;
        else                         count_reg      <= count_reg + 1'b1;
      end
    end
  end

  assign busy    = (state_reg == STATE_CALC);
  assign product = acc_reg;

endmodule

// File: rtl/multiplication_block.sv
// RV32M MUL/MULH/MULHSU/MULHU: sign handling around the unsigned shift-add core.
module multiplication_block
  import multiplication_block_pkg::*;
#(
  parameter int XLEN        = XLEN_DEFAULT,
  parameter int COUNT_WIDTH = $clog2(XLEN)
) (
  input  logic            CLK,
  input  logic            rst,
  input  logic [XLEN-1:0] multiplicand,
  input  logic [XLEN-1:0] multiplier,
  input  logic            data_valid,
  input  logic [1:0]      operation,
  output logic [XLEN-1:0] product_o,
  output logic            data_ready,
  output logic            busy
);

  mul_op_e           op_in;
  mul_op_e           op_reg;
  logic              negate_reg;
  logic              rs1_neg, rs2_neg;
  logic [XLEN-1:0]   rs1_mag, rs2_mag;
  logic              start;
  logic              unit_done;
  logic [2*XLEN-1:0] unit_product;
  logic [2*XLEN-1:0] corrected;

  assign op_in   = mul_op_e'(operation);
  // rs1 is unsigned only for MULHU; rs2 is signed only for MUL and MULH.
  assign rs1_neg = (op_in != OP_MULHU) && multiplicand[XLEN-1];
  assign rs2_neg = ((op_in == OP_MUL) || (op_in == OP_MULH)) && multiplier[XLEN-1];
  assign rs1_mag = rs1_neg ? -multiplicand : multiplicand;
  assign rs2_mag = rs2_neg ? -multiplier : multiplier;
  assign start   = data_valid && !busy;

  multiplication_unit #(
    .XLEN        (XLEN),
    .COUNT_WIDTH (COUNT_WIDTH)
  ) u_unit (
    .clk        (CLK),
    .srst       (rst),
    .start      (start),
    .mcand_mag  (rs1_mag),
    .mplier_mag (rs2_mag),
    .busy       (busy),
    .done       (unit_done),
    .product    (unit_product)
  );

  assign corrected = negate_reg ? -unit_product : unit_product;

  always_ff @(posedge CLK) begin
    if (rst) begin
      op_reg     <= OP_MUL;
      negate_reg <= 1'b0;
      product_o  <= '0;
      data_ready <= 1'b0;
    end else begin
      if (start) begin
        op_reg     <= op_in;
        negate_reg <= rs1_neg ^ rs2_neg;
      end
      data_ready <= unit_done;
      if (unit_done)
        product_o <= (op_reg == OP_MUL) ? corrected[XLEN-1:0] : corrected[2*XLEN-1:XLEN];
    end
  end

endmodule
